// File: rtl/iob_rom_sp_streamer_if.sv
// Command, ROM-port and stream signals of iob_rom_sp_streamer.
// IOB_ROM_STREAMER_LOOP_EN adds the loop_i command input.
interface iob_rom_sp_streamer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 11
);
  logic              start_i;
  logic [ADDR_W-1:0] start_addr_i;
  logic [ADDR_W:0]   len_i;
  logic              busy_o;
  logic              done_o;
  logic [ADDR_W-1:0] rom_addr_o;
  logic              rom_r_en_o;
  logic [DATA_W-1:0] rom_r_data_i;
  logic              m_valid_o;
  logic              m_ready_i;
  logic [DATA_W-1:0] m_data_o;
  logic              m_last_o;
`ifdef IOB_ROM_STREAMER_LOOP_EN
  logic              loop_i;

  modport master (
    input  start_i, start_addr_i, len_i, loop_i, rom_r_data_i, m_ready_i,
    output busy_o, done_o, rom_addr_o, rom_r_en_o, m_valid_o, m_data_o, m_last_o
  );

  modport slave (
    output start_i, start_addr_i, len_i, loop_i, rom_r_data_i, m_ready_i,
    input  busy_o, done_o, rom_addr_o, rom_r_en_o, m_valid_o, m_data_o, m_last_o
  );
`else
  modport master (
    input  start_i, start_addr_i, len_i, rom_r_data_i, m_ready_i,
    output busy_o, done_o, rom_addr_o, rom_r_en_o, m_valid_o, m_data_o, m_last_o
  );

  modport slave (
    output start_i, start_addr_i, len_i, rom_r_data_i, m_ready_i,
    input  busy_o, done_o, rom_addr_o, rom_r_en_o, m_valid_o, m_data_o, m_last_o
  );
`endif
endinterface

// File: rtl/iob_rom_sp_streamer.sv
// Walks a ROM address range and streams the words out through a 2-entry FIFO.
// Optional IOB_ROM_STREAMER_LOOP_EN: loop_i restarts the range without a bubble.
module iob_rom_sp_streamer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 11
) (
  input logic                   clk_i,
  input logic                   arst_n_i,
  iob_rom_sp_streamer_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [ADDR_W:0]   LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            r_state;
  state_t            w_stateNext;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_startAddr;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W:0]   r_issueCnt;
  logic              r_inflight;
  logic              r_inflightLast;
  logic [DATA_W-1:0] r_fifoData [2];
  logic [1:0]        r_fifoLast;
  logic              r_wrPtr;
  logic              r_rdPtr;
  logic [1:0]        r_count;

  logic              w_loop;
  logic              w_pop;
  logic [2:0]        w_occ;
  logic              w_credit;
  logic              w_finalPop;
  logic              w_issue;
  logic              w_issueLast;
  logic [ADDR_W-1:0] w_issueAddr;
  logic [ADDR_W-1:0] w_restartAddr;
  logic [ADDR_W:0]   w_issueIdx;
  logic [ADDR_W:0]   w_lenCur;
  logic              w_busy;
  logic              w_done;

`ifdef IOB_ROM_STREAMER_LOOP_EN
  assign w_loop = bus.loop_i;
`else
  assign w_loop = 1'b0;
`endif

  // Credit counts the word that leaves the FIFO this cycle, so 1 word/cycle holds at depth 2.
  assign bus.m_valid_o = (r_count != 2'd0);
  assign w_pop         = bus.m_valid_o & bus.m_ready_i;
  assign w_occ         = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_credit      = (w_occ < 3'd2);
  assign bus.m_data_o  = r_fifoData[r_rdPtr];
  assign bus.m_last_o  = r_fifoLast[r_rdPtr] & bus.m_valid_o;
  // Only the final word of a loop run leaves the FIFO with nothing behind it.
  assign w_finalPop    = w_pop & bus.m_last_o & (r_count == 2'd1) & ~r_inflight;

  // The first read goes out in the start cycle itself, straight from the command inputs.
  always_comb begin
    w_issueAddr   = r_addr;
    w_issueIdx    = r_issueCnt;
    w_lenCur      = r_len;
    w_restartAddr = r_startAddr;
    if (r_state == S_IDLE) begin
      w_issueAddr   = bus.start_addr_i;
      w_issueIdx    = '0;
      w_lenCur      = bus.len_i;
      w_restartAddr = bus.start_addr_i;
    end
  end

  assign w_issueLast = (w_issueIdx == (w_lenCur - LEN_ONE));

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) r_state <= S_IDLE;
    else           r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    w_issue     = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start_i) begin
          if (bus.len_i == '0) begin
            w_stateNext = S_DONE;
          end else begin
            w_issue     = 1'b1;
            w_stateNext = (w_issueLast && !w_loop) ? S_DRAIN : S_RUN;
          end
        end
      end
      S_RUN: begin
        w_busy  = 1'b1;
        w_issue = w_credit;
        if (w_credit && w_issueLast && !w_loop) w_stateNext = S_DRAIN;
      end
      S_DRAIN: begin
        w_busy = 1'b1;
        if (w_finalPop) w_stateNext = S_DONE;
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_stateNext = S_IDLE;
      end
      default: w_stateNext = S_IDLE;
    endcase
  end

  assign bus.busy_o     = w_busy;
  assign bus.done_o     = w_done;
  assign bus.rom_r_en_o = w_issue;
  assign bus.rom_addr_o = w_issue ? w_issueAddr : '0;

  // The returned word is always captured; credit guarantees a free FIFO slot.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_addr         <= '0;
      r_startAddr    <= '0;
      r_len          <= '0;
      r_issueCnt     <= '0;
      r_inflight     <= 1'b0;
      r_inflightLast <= 1'b0;
      r_fifoData[0]  <= '0;
      r_fifoData[1]  <= '0;
      r_fifoLast     <= '0;
      r_wrPtr        <= 1'b0;
      r_rdPtr        <= 1'b0;
      r_count        <= '0;
    end else begin
      if (r_state == S_IDLE && bus.start_i) begin
        r_startAddr <= bus.start_addr_i;
        r_len       <= bus.len_i;
      end
      if (w_issue) begin
        if (w_issueLast && w_loop) begin
          r_addr     <= w_restartAddr;
          r_issueCnt <= '0;
        end else begin
          r_addr     <= w_issueAddr + ADDR_ONE;
          r_issueCnt <= w_issueIdx + LEN_ONE;
        end
      end
      r_inflight     <= w_issue;
      r_inflightLast <= w_issue & w_issueLast;
      if (r_inflight) begin
        r_fifoData[r_wrPtr] <= bus.rom_r_data_i;
        r_fifoLast[r_wrPtr] <= r_inflightLast;
        r_wrPtr             <= ~r_wrPtr;
      end
      if (w_pop) r_rdPtr <= ~r_rdPtr;
      case ({r_inflight, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_iob_rom_sp_streamer.sv
// Directed bench for iob_rom_sp_streamer: scoreboard of expected words and ROM addresses.
// Define IOB_ROM_STREAMER_LOOP_EN to also exercise the loop feature.
module tb_iob_rom_sp_streamer;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 11;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

  logic clk_i;
  logic arst_n_i;

  iob_rom_sp_streamer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  iob_rom_sp_streamer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .bus      (bus)
  );

  logic [DATA_W-1:0] rom [DEPTH];
  beat_t             expQ[$];
  logic [ADDR_W-1:0] addrQ[$];

  int    errors = 0;
  int    checks = 0;
  int    cycleCnt = 0;
  int    readyMode = 0;
  int    readyPhase = 0;
  int    issued = 0;
  int    popped = 0;
  int    hsCnt = 0;
  int    hsBase = 0;
  int    doneCnt = 0;
  int    doneBase = 0;
  int    doneCycle = -1;
  int    firstValid = -1;
  int    firstHs = -1;
  int    lastHs = -1;
  int    startCycle = 0;
  int    lastIssueCnt = 0;
  logic  loopArm = 1'b0;
  logic  stallPrev = 1'b0;
  beat_t held;

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  always @(posedge clk_i) begin
    if (bus.rom_r_en_o) bus.rom_r_data_i <= rom[bus.rom_addr_o];
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_flags"}, 64'({bus.busy_o, bus.done_o, bus.m_valid_o, bus.rom_r_en_o, bus.m_last_o}), 64'(0));
    checkOutput({tag, "_rom_addr"}, 64'(bus.rom_addr_o), 64'(0));
    checkOutput({tag, "_m_data"}, 64'(bus.m_data_o), 64'(0));
  endtask

  // Ready pattern and loop_i are changed just after each rising edge.
  initial begin
    bus.m_ready_i = 1'b1;
    forever begin
      @(posedge clk_i);
      cycleCnt++;
      #1;
      if (readyMode == 0) begin
        bus.m_ready_i = 1'b1;
      end else begin
        bus.m_ready_i = (readyPhase % 3 == 0);
        readyPhase++;
      end
`ifdef IOB_ROM_STREAMER_LOOP_EN
      if (loopArm && lastIssueCnt >= 2) bus.loop_i = 1'b0;
`endif
    end
  end

  // Monitor samples on the falling edge, between rising edges.
  initial begin
    beat_t             expBeat;
    logic [ADDR_W-1:0] expAddr;
    int                outstanding;
    logic              popNow;
    forever begin
      @(negedge clk_i);
      if (!arst_n_i) begin
        stallPrev = 1'b0;
      end else begin
        popNow = bus.m_valid_o & bus.m_ready_i;
        if (stallPrev) begin
          checkOutput("stall_valid", 64'(bus.m_valid_o), 64'(1));
          checkOutput("stall_hold", 64'({bus.m_data_o, bus.m_last_o}), 64'(held));
        end
        if (bus.rom_r_en_o) begin
          outstanding = issued - popped - (popNow ? 1 : 0);
          checkOutput("credit", 64'(outstanding < 2), 64'(1));
          issued++;
          checkOutput("read_expected", 64'(addrQ.size() != 0), 64'(1));
          if (addrQ.size() != 0) begin
            expAddr = addrQ.pop_front();
            checkOutput("rom_addr", 64'(bus.rom_addr_o), 64'(expAddr));
          end
`ifdef IOB_ROM_STREAMER_LOOP_EN
          if (loopArm && bus.rom_addr_o == 11'h022) lastIssueCnt++;
`endif
        end
        if (popNow) begin
          popped++;
          hsCnt++;
          if (firstHs < 0) firstHs = cycleCnt;
          lastHs = cycleCnt;
          checkOutput("word_expected", 64'(expQ.size() != 0), 64'(1));
          if (expQ.size() != 0) begin
            expBeat = expQ.pop_front();
            checkOutput("m_data", 64'(bus.m_data_o), 64'(expBeat.data));
            checkOutput("m_last", 64'(bus.m_last_o), 64'(expBeat.last));
          end
        end
        if (bus.done_o) begin
          doneCnt++;
          doneCycle = cycleCnt;
          checkOutput("busy_at_done", 64'(bus.busy_o), 64'(0));
        end
        if (bus.m_valid_o && firstValid < 0) firstValid = cycleCnt;
        stallPrev = bus.m_valid_o & ~bus.m_ready_i;
        held      = {bus.m_data_o, bus.m_last_o};
      end
    end
  end

  task automatic applyStimulus(input logic [ADDR_W-1:0] addr, input int len, input int passes);
    beat_t             b;
    logic [ADDR_W-1:0] a;
    for (int p = 0; p < passes; p++) begin
      for (int i = 0; i < len; i++) begin
        a      = addr + ADDR_W'(i);
        b.data = rom[a];
        b.last = (i == len - 1);
        expQ.push_back(b);
        addrQ.push_back(a);
      end
    end
    hsBase     = hsCnt;
    doneBase   = doneCnt;
    firstValid = -1;
    firstHs    = -1;
    lastHs     = -1;
    startCycle = cycleCnt;
    bus.start_addr_i = addr;
    bus.len_i        = (ADDR_W+1)'(len);
    bus.start_i      = 1'b1;
    @(posedge clk_i);
    #2;
    bus.start_i = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int budget, input int expWords);
    int n;
    n = 0;
    while (doneCnt == doneBase && n < budget) begin
      @(posedge clk_i);
      #2;
      n++;
    end
    checkOutput({tag, "_finished"}, 64'(doneCnt != doneBase), 64'(1));
    repeat (3) begin
      @(posedge clk_i);
      #2;
    end
    checkOutput({tag, "_done_once"}, 64'(doneCnt - doneBase), 64'(1));
    checkOutput({tag, "_words"}, 64'(hsCnt - hsBase), 64'(expWords));
    checkOutput({tag, "_sb_empty"}, 64'(expQ.size() + addrQ.size()), 64'(0));
    checkOutput({tag, "_busy_idle"}, 64'(bus.busy_o), 64'(0));
  endtask

  initial begin
    int n;
    int issuedBase;
    for (int i = 0; i < DEPTH; i++) rom[i] = 32'hC0DE_0000 | 32'(i);
    arst_n_i         = 1'b0;
    bus.start_i      = 1'b0;
    bus.start_addr_i = '0;
    bus.len_i        = '0;
`ifdef IOB_ROM_STREAMER_LOOP_EN
    bus.loop_i       = 1'b0;
`endif
    repeat (3) @(posedge clk_i);
    #2;
    checkIdleOutputs("reset");
    arst_n_i = 1'b1;
    @(posedge clk_i);
    #2;

    $display("[TB] basic transfer");
    applyStimulus(11'h010, 4, 1);
    waitDone("basic", 50, 4);
    checkOutput("basic_latency", 64'(firstValid - startCycle), 64'(2));
    checkOutput("basic_back2back", 64'(lastHs - firstHs), 64'(3));
    checkOutput("basic_done_cycle", 64'(doneCycle - lastHs), 64'(1));

    $display("[TB] backpressure");
    readyMode  = 1;
    readyPhase = 0;
    applyStimulus(11'h100, 8, 1);
    waitDone("bp", 200, 8);
    readyMode = 0;

    $display("[TB] address wrap");
    applyStimulus(11'h7FE, 4, 1);
    waitDone("wrap", 50, 4);

    $display("[TB] zero length");
    issuedBase = issued;
    applyStimulus(11'h055, 0, 1);
    waitDone("len0", 20, 0);
    checkOutput("len0_no_reads", 64'(issued - issuedBase), 64'(0));
    checkOutput("len0_no_valid", 64'(firstValid), 64'(-1));

    $display("[TB] single word");
    applyStimulus(11'h3A0, 1, 1);
    waitDone("len1", 20, 1);
    checkOutput("len1_latency", 64'(firstValid - startCycle), 64'(2));

    $display("[TB] full ROM");
    applyStimulus(11'h123, DEPTH, 1);
    waitDone("full", 3000, DEPTH);
    checkOutput("full_rate", 64'(lastHs - firstHs), 64'(DEPTH - 1));

    $display("[TB] start while busy");
    readyMode  = 1;
    readyPhase = 0;
    applyStimulus(11'h200, 8, 1);
    repeat (3) begin
      @(posedge clk_i);
      #2;
    end
    bus.start_addr_i = 11'h600;
    bus.len_i        = 12'd5;
    bus.start_i      = 1'b1;
    @(posedge clk_i);
    #2;
    bus.start_i = 1'b0;
    checkOutput("ignore_busy", 64'(bus.busy_o), 64'(1));
    waitDone("ignore", 200, 8);
    readyMode = 0;

    $display("[TB] reset mid-transfer");
    applyStimulus(11'h300, 8, 1);
    n = 0;
    while (hsCnt - hsBase < 3 && n < 50) begin
      @(posedge clk_i);
      #2;
      n++;
    end
    checkOutput("rst_progress", 64'(hsCnt - hsBase >= 3), 64'(1));
    #1;
    arst_n_i = 1'b0;
    #1;
    checkIdleOutputs("async_rst");
    expQ.delete();
    addrQ.delete();
    issued   = 0;
    popped   = 0;
    doneBase = doneCnt;
    repeat (2) @(posedge clk_i);
    #2;
    checkOutput("rst_no_done", 64'(doneCnt - doneBase), 64'(0));
    arst_n_i = 1'b1;
    @(posedge clk_i);
    #2;
    applyStimulus(11'h040, 3, 1);
    waitDone("post_rst", 50, 3);

`ifdef IOB_ROM_STREAMER_LOOP_EN
    $display("[TB] loop passes");
    bus.loop_i   = 1'b1;
    lastIssueCnt = 0;
    loopArm      = 1'b1;
    applyStimulus(11'h020, 3, 3);
    waitDone("loop", 100, 9);
    checkOutput("loop_no_bubble", 64'(lastHs - firstHs), 64'(8));
    loopArm    = 1'b0;
    bus.loop_i = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
